boot_loader: RTL and testbench

- Sits directly downstream of the UART receiver in the ECP5 bootstrap path.
- Consumes the byte stream (packet_en/data), the end-of-buffer strobe (buffer_finish) and the UART timeout.
- Packs bytes little-endian into 32-bit words and writes them to program memory through a small FIFO with a valid/ready write port.
- Verifies length and an 8-bit additive checksum, then either releases the core (run) or reports a sticky error code.

---
 rtl/boot_loader.sv | 135 +++++++++++++
 tb/tb_boot_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: packs UART bytes little-endian into 32-bit words, streams them to
// program memory through a small FWFT FIFO, then checks length and checksum.
module boot_loader #(
   parameter int NUM_PACKETS = 256,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_W      = $clog2(NUM_PACKETS/4)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              packet_en,
   input  logic [7:0]        data,
   input  logic              buffer_finish,
   input  logic              timeout,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              run,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [7:0]        checksum
);

   localparam int IDX_W = $clog2(NUM_PACKETS) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {LOAD, DRAIN, DONE, ERROR} state_t;

   state_t           state;
   logic [IDX_W-1:0] byte_idx;
   logic [23:0]      asm_word;
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic        overflow;
   logic        last_byte;
   logic        len_bad;
   logic [31:0] push_word;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign mem_we    = !fifo_empty && (state == LOAD || state == DRAIN);
   assign mem_wdata = mem_we ? fifo_mem[rd_ptr[PTR_W-1:0]] : 32'd0;
   assign pop       = mem_we && mem_ready;

   assign push      = (state == LOAD) && packet_en && (byte_idx[1:0] == 2'd3);
   assign push_word = {data, asm_word};
   assign overflow  = push && fifo_full && !pop;

   // A length fault is either finishing early or running past the image without a finish
   assign last_byte = (byte_idx == IDX_W'(NUM_PACKETS - 1));
   assign len_bad   = (state == LOAD) && packet_en && (buffer_finish != last_byte);

   always_ff @(posedge clk) begin
      if (state == LOAD && packet_en) begin
         case (byte_idx[1:0])
            2'd0:    asm_word[7:0]   <= data;
            2'd1:    asm_word[15:8]  <= data;
            2'd2:    asm_word[23:16] <= data;
            default: ;
         endcase
      end
      if (push && !overflow)
         fifo_mem[wr_ptr[PTR_W-1:0]] <= push_word;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= LOAD;
         byte_idx <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_addr <= '0;
         run      <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'd0;
         checksum <= 8'd0;
      end else begin
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            mem_addr <= mem_addr + 1'b1;
         end
         if (push && !overflow)
            wr_ptr <= wr_ptr + 1'b1;

         case (state)
            LOAD: begin
               if (packet_en) begin
                  checksum <= checksum + data;
                  byte_idx <= byte_idx + 1'b1;
               end
               if (overflow) begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  err_code <= 2'd1;
               end else if (len_bad) begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  err_code <= 2'd2;
               end else if (timeout) begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  err_code <= 2'd0;
               end else if (packet_en && buffer_finish) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  if (checksum == 8'd0) begin
                     state <= DONE;
                     run   <= 1'b1;
                  end else begin
                     state    <= ERROR;
                     error    <= 1'b1;
                     err_code <= 2'd3;
                  end
               end
            end
            // Queued words are abandoned once the load has failed
            ERROR:   rd_ptr <= wr_ptr;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (8-byte/4-deep and 16-byte/2-deep) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       packet_en = 1'b0;
   logic [7:0] data = 8'd0;
   logic       buffer_finish = 1'b0;
   logic       timeout = 1'b0;
   logic       mem_ready = 1'b1;

   logic        we_a, run_a, error_a;
   logic [0:0]  addr_a;
   logic [31:0] wdata_a;
   logic [1:0]  code_a;
   logic [7:0]  sum_a;

   logic        we_b, run_b, error_b;
   logic [1:0]  addr_b;
   logic [31:0] wdata_b;
   logic [1:0]  code_b;
   logic [7:0]  sum_b;

   boot_loader #(.NUM_PACKETS(8), .FIFO_DEPTH(4), .ADDR_W(1)) u_a (
      .clk(clk), .n_rst(n_rst), .packet_en(packet_en), .data(data),
      .buffer_finish(buffer_finish), .timeout(timeout), .mem_we(we_a),
      .mem_ready(mem_ready), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .run(run_a), .error(error_a), .err_code(code_a), .checksum(sum_a));

   boot_loader #(.NUM_PACKETS(16), .FIFO_DEPTH(2), .ADDR_W(2)) u_b (
      .clk(clk), .n_rst(n_rst), .packet_en(packet_en), .data(data),
      .buffer_finish(buffer_finish), .timeout(timeout), .mem_we(we_b),
      .mem_ready(mem_ready), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .run(run_b), .error(error_b), .err_code(code_b), .checksum(sum_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- model: states 0=LOAD 1=DRAIN 2=DONE 3=ERROR ----------------
   int          np [2] = '{8, 16};
   int          dp [2] = '{4, 2};
   int          amod [2] = '{2, 4};
   int          mst [2];
   int          midx [2];
   int          mcnt [2];
   int          mcode [2];
   int          maddr [2];
   logic [7:0]  msum [2];
   logic [31:0] masm [2];
   logic [31:0] mq [2][4];

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         mst[i] = 0; midx[i] = 0; mcnt[i] = 0; mcode[i] = 0; maddr[i] = 0;
         msum[i] = 8'd0; masm[i] = 32'd0;
      end
   endtask

   task automatic step(input int i);
      bit          we, pop, push, ovf, lenb;
      int          nxt, ncode, old;
      logic [31:0] w;
      we = (mst[i] <= 1) && (mcnt[i] > 0);
      pop = we && mem_ready;
      push = 0; ovf = 0; lenb = 0; w = 32'd0;
      nxt = mst[i]; ncode = mcode[i];
      if (mst[i] == 0) begin
         if (packet_en) begin
            msum[i] = msum[i] + data;
            old = midx[i];
            masm[i] = masm[i] | (32'(data) << (8 * (old % 4)));
            if (old % 4 == 3) begin
               push = 1; w = masm[i]; masm[i] = 32'd0;
            end
            midx[i] = old + 1;
            lenb = buffer_finish ? (old != np[i] - 1) : (old == np[i] - 1);
         end
         ovf = push && (mcnt[i] == dp[i]) && !pop;
         if (ovf) begin nxt = 3; ncode = 1; end
         else if (lenb) begin nxt = 3; ncode = 2; end
         else if (timeout) begin nxt = 3; ncode = 0; end
         else if (packet_en && buffer_finish) nxt = 1;
      end else if (mst[i] == 1 && mcnt[i] == 0) begin
         if (msum[i] == 8'd0) nxt = 2;
         else begin nxt = 3; ncode = 3; end
      end
      if (pop) begin
         for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
         mcnt[i]--;
         maddr[i]++;
      end
      if (push && !ovf) begin
         mq[i][mcnt[i]] = w;
         mcnt[i]++;
      end
      if (nxt == 3 && mst[i] != 3) begin
         mcnt[i] = 0;
         mcode[i] = ncode;
      end
      mst[i] = nxt;
   endtask

   always begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) mreset();
      else begin
         step(0);
         step(1);
      end
   end

   task automatic cmp_inst(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic run, input logic err,
                           input logic [1:0] code, input logic [7:0] sum);
      logic ew;
      ew = (mst[i] <= 1) && (mcnt[i] > 0);
      chk($sformatf("u%0d.mem_we", i), 32'(we), 32'(ew));
      chk($sformatf("u%0d.mem_addr", i), addr, 32'(maddr[i] % amod[i]));
      chk($sformatf("u%0d.mem_wdata", i), wdata, ew ? mq[i][0] : 32'd0);
      chk($sformatf("u%0d.run", i), 32'(run), 32'(mst[i] == 2));
      chk($sformatf("u%0d.error", i), 32'(err), 32'(mst[i] == 3));
      chk($sformatf("u%0d.err_code", i), 32'(code), 32'(mcode[i]));
      chk($sformatf("u%0d.checksum", i), 32'(sum), 32'(msum[i]));
   endtask

   always begin
      @(negedge clk);
      cmp_inst(0, we_a, 32'(addr_a), wdata_a, run_a, error_a, code_a, sum_a);
      cmp_inst(1, we_b, 32'(addr_b), wdata_b, run_b, error_b, code_b, sum_b);
   end

   // Completed writes of the 8-byte instance, sampled just before the active edge
   logic [31:0] log_data [64];
   int          log_addr [64];
   int          log_n = 0;

   always begin
      @(negedge clk);
      #4;
      if (n_rst && we_a && mem_ready && log_n < 64) begin
         log_data[log_n] = wdata_a;
         log_addr[log_n] = 32'(addr_a);
         log_n++;
      end
   end

   // 01+02+...+07 = 0x1C, so E4 brings the image sum to 0
   logic [7:0] img [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hE4};

   task automatic send_byte(input logic [7:0] b, input logic bf, input int gap);
      packet_en = 1'b1; data = b; buffer_finish = bf;
      @(negedge clk);
      packet_en = 1'b0; buffer_finish = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_img(input logic [7:0] last, input int gap);
      for (int i = 0; i < 8; i++)
         send_byte((i == 7) ? last : img[i], i == 7, gap);
   endtask

   task automatic reset_dut();
      #2 n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1; timeout = 1'b0; packet_en = 1'b0; buffer_finish = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_good(input string tag, input int lb);
      chk({tag, ".writes"}, 32'(log_n - lb), 32'd2);
      chk({tag, ".w0_data"}, log_data[lb], 32'h04030201);
      chk({tag, ".w0_addr"}, 32'(log_addr[lb]), 32'd0);
      chk({tag, ".w1_data"}, log_data[lb+1], 32'hE4070605);
      chk({tag, ".w1_addr"}, 32'(log_addr[lb+1]), 32'd1);
      chk({tag, ".run"}, 32'(run_a), 32'd1);
      chk({tag, ".error"}, 32'(error_a), 32'd0);
      chk({tag, ".checksum"}, 32'(sum_a), 32'd0);
   endtask

   int lb;

   initial begin
      mreset();
      repeat (3) @(negedge clk);
      chk("rst.mem_we", 32'(we_a), 32'd0);
      chk("rst.mem_addr", 32'(addr_a), 32'd0);
      chk("rst.mem_wdata", wdata_a, 32'd0);
      chk("rst.run", 32'(run_a), 32'd0);
      chk("rst.error", 32'(error_a), 32'd0);
      chk("rst.checksum", 32'(sum_a), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      // good image, memory always ready
      lb = log_n;
      mem_ready = 1'b1;
      send_img(8'hE4, 1);
      repeat (8) @(negedge clk);
      check_good("good", lb);
      chk("good.b_error", 32'(error_b), 32'd1);
      chk("good.b_code", 32'(code_b), 32'd2);

      // backpressure
      reset_dut();
      lb = log_n;
      mem_ready = 1'b0;
      fork
         begin repeat (20) @(negedge clk); mem_ready = 1'b1; end
      join_none
      send_img(8'hE4, 10);
      repeat (8) @(negedge clk);
      check_good("bp", lb);

      // bad checksum
      reset_dut();
      lb = log_n;
      mem_ready = 1'b1;
      send_img(8'hE3, 1);
      repeat (8) @(negedge clk);
      chk("badsum.error", 32'(error_a), 32'd1);
      chk("badsum.code", 32'(code_a), 32'd3);
      chk("badsum.run", 32'(run_a), 32'd0);
      chk("badsum.writes", 32'(log_n - lb), 32'd2);
      chk("badsum.checksum", 32'(sum_a), 32'hFF);

      // timeout after three bytes
      reset_dut();
      lb = log_n;
      for (int i = 0; i < 3; i++) send_byte(img[i], 1'b0, 1);
      timeout = 1'b1;
      @(negedge clk);
      timeout = 1'b0;
      repeat (3) @(negedge clk);
      chk("tmo.error", 32'(error_a), 32'd1);
      chk("tmo.code", 32'(code_a), 32'd0);
      chk("tmo.writes", 32'(log_n - lb), 32'd0);
      chk("tmo.b_code", 32'(code_b), 32'd0);

      // finish flagged on the fifth byte
      reset_dut();
      for (int i = 0; i < 5; i++) send_byte(img[i], i == 4, 1);
      repeat (3) @(negedge clk);
      chk("early.error", 32'(error_a), 32'd1);
      chk("early.code", 32'(code_a), 32'd2);

      // overflow on the 2-deep instance with memory stalled
      reset_dut();
      mem_ready = 1'b0;
      for (int i = 0; i < 11; i++) send_byte(8'(i + 1), 1'b0, 0);
      packet_en = 1'b1; data = 8'd12;
      chk("ovf.b_we_before", 32'(we_b), 32'd1);
      @(negedge clk);
      packet_en = 1'b0;
      chk("ovf.b_error", 32'(error_b), 32'd1);
      chk("ovf.b_code", 32'(code_b), 32'd1);
      chk("ovf.b_we_after", 32'(we_b), 32'd0);
      repeat (2) @(negedge clk);

      // asynchronous reset mid-load, then the full image again
      reset_dut();
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0, 1);
      #2 n_rst = 1'b0;
      #1;
      chk("arst.mem_we", 32'(we_a), 32'd0);
      chk("arst.mem_addr", 32'(addr_a), 32'd0);
      chk("arst.mem_wdata", wdata_a, 32'd0);
      chk("arst.checksum", 32'(sum_a), 32'd0);
      chk("arst.error", 32'(error_a), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      lb = log_n;
      send_img(8'hE4, 1);
      repeat (8) @(negedge clk);
      check_good("resend", lb);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
